i2s_rx_core: RTL and testbench
==============================

I2S_RX_CORE -- requirements
Module: i2s_rx_core

Interface
REQ-001 Parameter DW, default 8, sample word width per channel (DW >= 2).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 sck_i  input  1  I2S serial clock from external master, asynchronous to clk, sck_i frequency <= clk/4.
REQ-005 ws_i  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-006 sd_i  input  1  I2S serial data, asynchronous, MSB first.
REQ-007 rx_left  output  DW  received left sample of the presented frame.
REQ-008 rx_right  output  DW  received right sample of the presented frame.
REQ-009 rx_valid  output  1  frame (left + right) available.
REQ-010 rx_ready  input  1  consumer accepts the frame when rx_valid & rx_ready.
REQ-011 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-012 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-013 sck_i, ws_i and sd_i SHALL each pass through a 2-flop synchronizer; an sck strobe SHALL be generated for one clk on each synchronized sck rising edge.
REQ-014 On each sck strobe the block SHALL sample synchronized ws and sd together; ws_prev holds the ws value from the previous strobe.
REQ-015 Transition strobe: ws sample != ws_prev; the sd bit at that strobe is the LSB of the word of channel ws_prev; the next strobe carries the MSB of the new word.
REQ-016 State SYNC (after reset): bits are discarded; on the first transition strobe, go to RUN with shift register and bit counter cleared, nothing committed.
REQ-017 State RUN: each strobe with bit counter < DW SHALL write sd to bit position DW-1-count and increment count; count saturates at DW, extra bits ignored (MSB-aligned truncation).
REQ-018 Words shorter than DW bits SHALL be zero-padded in the LSBs.
REQ-019 On a transition strobe in RUN, the final bit is included (if count < DW), the word is committed to channel ws_prev, then shift register and count are cleared in the same clk.
REQ-020 A committed left word SHALL be held with a left_held flag; a committed right word with left_held = 0 SHALL be discarded.
REQ-021 A committed right word with left_held = 1 completes a frame; left_held is cleared.
REQ-022 On frame completion with rx_valid = 0, or rx_valid = 1 and rx_ready = 1 in the same clk, rx_left/rx_right SHALL load and rx_valid SHALL be 1 on the next clk.
REQ-023 On frame completion with rx_valid = 1 and rx_ready = 0, the new frame SHALL be dropped, outputs unchanged, overrun set to 1 on the next clk.
REQ-024 rx_left/rx_right SHALL remain stable while rx_valid = 1; rx_valid clears the clk after rx_valid & rx_ready unless REQ-022 reloads.
REQ-025 clr_overrun clears overrun; simultaneous set and clear SHALL leave overrun = 1.
REQ-026 Latency: rx_valid rises at most 5 clk after the sck_i rising edge that samples the ws 1->0 transition.

Reset
REQ-027 reset_n low SHALL force state SYNC; rx_left = 0, rx_right = 0, rx_valid = 0, overrun = 0; synchronizers, ws_prev, shift register, count and left_held = 0.
REQ-028 Reset mid-word or mid-frame SHALL discard all partial data; reception resumes only after the next ws transition.

Structure
REQ-029 A shared i2s package SHALL hold the state enum (SYNC, RUN) and channel constants LEFT = 0, RIGHT = 1.
REQ-030 One sub-module, i2s_sync2 (2-flop synchronizer, 1 bit), SHALL be instantiated three times; the rest stays flat.

Verification
REQ-031 DW=8, clk = 8x sck, stereo stream L=0xA5 R=0x3C, rx_ready=1 -> first frame after sync is rx_left=0xA5, rx_right=0x3C, rx_valid 1 clk per frame, overrun=0.
REQ-032 Start of stream mid-word (ws=1 already, 3 bits in) -> partial word dropped; first presented frame is the first full L/R pair.
REQ-033 16-bit words 0x1234/0xABCD on bus with DW=8 -> rx_left=0x12, rx_right=0xAB; 6-bit words 0b101101 -> rx_left=0xB4.
REQ-034 rx_ready=0 across two frames -> first frame held stable, second dropped, overrun=1; pulse clr_overrun -> overrun=0.
REQ-035 reset_n pulsed low mid-right-word -> all outputs 0 next clk; no frame until a full L/R pair after the next ws transition.
REQ-036 Right word committed with no preceding left (ws toggles 0->1->0 with only right data valid after sync) -> no rx_valid.

Source files
------------

// File: rtl/i2s_rx_core_pkg.sv
// Shared I2S receive definitions: FSM states and channel encoding.
package i2s_rx_core_pkg;

  // Receiver framing state: hunting for the first word boundary, or receiving
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Word-select encoding of the two channels
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync2.sv
// Two-flop synchronizer for one asynchronous bit into the clk domain.
module i2s_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the input to settle metastability
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2s_rx_core.sv
// I2S slave receiver: deserializes left/right words and presents stereo frames
// through a valid/ready handshake with a sticky overrun flag.
module i2s_rx_core
  import i2s_rx_core_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sck_i,
  input  logic          ws_i,
  input  logic          sd_i,
  output logic [DW-1:0] rx_left,
  output logic [DW-1:0] rx_right,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          overrun,
  input  logic          clr_overrun
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic sck_s;
  logic ws_s;
  logic sd_s;

  i2s_sync2 u_sync_sck (.clk(clk), .reset_n(reset_n), .d_i(sck_i), .q_o(sck_s));
  i2s_sync2 u_sync_ws  (.clk(clk), .reset_n(reset_n), .d_i(ws_i),  .q_o(ws_s));
  i2s_sync2 u_sync_sd  (.clk(clk), .reset_n(reset_n), .d_i(sd_i),  .q_o(sd_s));

  state_e          state_q,     state_d;
  logic            sck_prev_q;
  logic            ws_prev_q,   ws_prev_d;
  logic [DW-1:0]   shift_q,     shift_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic            left_held_q, left_held_d;
  logic [DW-1:0]   left_word_q, left_word_d;
  logic [DW-1:0]   rx_left_q,   rx_left_d;
  logic [DW-1:0]   rx_right_q,  rx_right_d;
  logic            rx_valid_q,  rx_valid_d;
  logic            overrun_q,   overrun_d;

  logic            strobe_c;
  logic            trans_c;
  logic            room_c;
  logic [CW-1:0]   pos_c;
  logic [DW-1:0]   mask_c;
  logic [DW-1:0]   word_c;
  logic            frame_done_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      sck_prev_q  <= 1'b0;
      ws_prev_q   <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      left_held_q <= 1'b0;
      left_word_q <= '0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_s;
      ws_prev_q   <= ws_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      left_held_q <= left_held_d;
      left_word_q <= left_word_d;
      rx_left_q   <= rx_left_d;
      rx_right_q  <= rx_right_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: bit capture, word commit, frame pairing and output handshake
  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    left_held_d  = left_held_q;
    left_word_d  = left_word_q;
    rx_left_d    = rx_left_q;
    rx_right_d   = rx_right_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;
    frame_done_c = 1'b0;

    strobe_c = sck_s & ~sck_prev_q;
    trans_c  = strobe_c & (ws_s != ws_prev_q);
    room_c   = (cnt_q < CW'(DW));
    // Position is only meaningful while there is room; masked by room_c otherwise
    pos_c    = CW'(DW - 1) - cnt_q;
    mask_c   = DW'(1) << pos_c;
    word_c   = (room_c && sd_s) ? (shift_q | mask_c) : shift_q;

    if (strobe_c) begin
      ws_prev_d = ws_s;
    end

    case (state_q)
      SYNC: begin
        if (trans_c) begin
          state_d = RUN;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (trans_c) begin
          shift_d = '0;
          cnt_d   = '0;
          if (ws_prev_q == LEFT) begin
            left_word_d = word_c;
            left_held_d = 1'b1;
          end else if (left_held_q) begin
            frame_done_c = 1'b1;
            left_held_d  = 1'b0;
          end
        end else if (strobe_c && room_c) begin
          shift_d = word_c;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    // A completed frame either loads the output slot or is dropped as overrun
    if (frame_done_c) begin
      if (!rx_valid_q || rx_ready) begin
        rx_left_d  = left_word_q;
        rx_right_d = word_c;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_left  = rx_left_q;
  assign rx_right = rx_right_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2s_rx_core.sv
// Bench for i2s_rx_core: drives I2S word streams and checks presented frames
// against a word-level reference model.
module tb_i2s_rx_core;

  localparam int unsigned DW = 8;

  typedef struct {
    logic        ch;
    logic [31:0] val;
    int          nb;
  } word_t;

  logic          clk;
  logic          reset_n;
  logic          sck_i;
  logic          ws_i;
  logic          sd_i;
  logic [DW-1:0] rx_left;
  logic [DW-1:0] rx_right;
  logic          rx_valid;
  logic          rx_ready;
  logic          overrun;
  logic          clr_overrun;

  int n_checks;
  int n_errors;

  word_t       words[$];
  logic        sd_q[$];
  logic        ws_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  logic ws_seen;
  time  t_trans;
  time  t_valid_rise;

  i2s_rx_core #(.DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sck_i       (sck_i),
    .ws_i        (ws_i),
    .sd_i        (sd_i),
    .rx_left     (rx_left),
    .rx_right    (rx_right),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted frame
  always @(negedge clk) begin
    if (reset_n && rx_valid && rx_ready) obs_q.push_back({rx_left, rx_right});
  end

  // Timestamp the sck edge that samples a ws 1->0 change, and the rx_valid rise
  initial ws_seen = 1'b0;
  always @(posedge sck_i) begin
    if (ws_seen && !ws_i) t_trans = $time;
    ws_seen = ws_i;
  end
  always @(posedge rx_valid) t_valid_rise = $time;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MSB-aligned: keep the top DW bits, zero-pad short words on the right
  function automatic logic [7:0] norm(input logic [31:0] v, input int nb);
    if (nb >= int'(DW)) return 8'(v >> (nb - int'(DW)));
    return 8'(v << (int'(DW) - nb));
  endfunction

  task automatic add_word(input logic ch, input logic [31:0] val, input int nb);
    word_t w;
    logic [31:0] m;
    m = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    w.ch  = ch;
    w.val = val & m;
    w.nb  = nb;
    words.push_back(w);
  endtask

  // Reference: first word is lost to alignment, last word never closes;
  // a left word followed by a right word forms a frame, a lone right is dropped.
  task automatic model();
    logic       held;
    logic [7:0] lw;
    held = 1'b0;
    lw   = 8'h00;
    exp_q.delete();
    for (int i = 1; i < words.size() - 1; i++) begin
      if (words[i].ch == 1'b0) begin
        held = 1'b1;
        lw   = norm(words[i].val, words[i].nb);
      end else if (held) begin
        exp_q.push_back({lw, norm(words[i].val, words[i].nb)});
        held = 1'b0;
      end
    end
  endtask

  // Serialize MSB first; ws switches one bit ahead of each new word
  task automatic build();
    logic ch_q[$];
    sd_q.delete();
    ws_q.delete();
    foreach (words[i]) begin
      for (int b = words[i].nb - 1; b >= 0; b--) begin
        sd_q.push_back(words[i].val[b]);
        ch_q.push_back(words[i].ch);
      end
    end
    for (int k = 0; k < ch_q.size(); k++)
      ws_q.push_back((k + 1 < ch_q.size()) ? ch_q[k + 1] : ch_q[k]);
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      ws_i  = ws_q[k];
      sd_i  = sd_q[k];
      #40;
      sck_i = 1'b1;
      #40;
      sck_i = 1'b0;
    end
  endtask

  task automatic run_stream();
    build();
    model();
    obs_q.delete();
    send(sd_q.size());
    repeat (30) @(posedge clk);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_frame%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    words.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [31:0] a, b;
    n_checks    = 0;
    n_errors    = 0;
    reset_n     = 1'b0;
    sck_i       = 1'b0;
    ws_i        = 1'b0;
    sd_i        = 1'b0;
    rx_ready    = 1'b1;
    clr_overrun = 1'b0;
    t_trans     = 0;
    t_valid_rise = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_left",    32'(rx_left),  32'h0);
    check("rst_right",   32'(rx_right), 32'h0);
    check("rst_valid",   32'(rx_valid), 32'h0);
    check("rst_overrun", 32'(overrun),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fixed stereo pattern A5/3C, plus latency from the closing ws edge
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_word(1'b0, 32'hA5, 8);
      add_word(1'b1, 32'h3C, 8);
    end
    add_word(1'b0, 32'hA5, 8);
    run_stream();
    compare_frames("a5_3c");
    check("a5_3c_frame0_exact", 32'(obs_q.size() > 0 ? obs_q[0] : 16'h0), 32'hA53C);
    check("a5_3c_overrun", 32'(overrun), 32'h0);
    check("latency_le_5clk",
          32'((t_valid_rise >= t_trans) && (t_valid_rise - t_trans <= 50)), 32'h1);

    // Start mid-word with ws already right: partial word discarded
    do_reset();
    add_word(1'b1, $urandom, 5);
    for (int i = 0; i < 3; i++) begin
      add_word(1'b0, $urandom, 8);
      add_word(1'b1, $urandom, 8);
    end
    add_word(1'b0, $urandom, 8);
    run_stream();
    compare_frames("midword");

    // Long words truncate, short words pad
    do_reset();
    add_word(1'b0, 32'h1234, 16);
    add_word(1'b1, 32'hABCD, 16);
    add_word(1'b0, 32'h1234, 16);
    add_word(1'b1, 32'hABCD, 16);
    add_word(1'b0, 32'h2D, 6);
    add_word(1'b1, 32'h13, 6);
    add_word(1'b0, 32'h2D, 6);
    run_stream();
    compare_frames("widths");
    check("trunc_exact", 32'(obs_q.size() > 0 ? obs_q[0] : 16'h0), 32'h12AB);
    check("pad_exact",   32'(obs_q.size() > 1 ? obs_q[1] : 16'h0), 32'hB44C);

    // Random values and word lengths
    do_reset();
    for (int i = 0; i < 14; i++)
      add_word(1'(i % 2), $urandom, int'($urandom_range(2, 16)));
    run_stream();
    compare_frames("random");

    // Backpressure: first frame held, second dropped, overrun sticky
    do_reset();
    rx_ready = 1'b0;
    a = $urandom; b = $urandom;
    add_word(1'b0, $urandom, 8);
    add_word(1'b1, $urandom, 8);
    add_word(1'b0, a, 8);
    add_word(1'b1, b, 8);
    add_word(1'b0, $urandom, 8);
    add_word(1'b1, $urandom, 8);
    add_word(1'b0, $urandom, 8);
    run_stream();
    check("bp_valid",   32'(rx_valid), 32'h1);
    check("bp_left",    32'(rx_left),  32'(a[7:0]));
    check("bp_right",   32'(rx_right), 32'(b[7:0]));
    check("bp_overrun", 32'(overrun),  32'h1);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("bp_clr_overrun", 32'(overrun),  32'h0);
    check("bp_still_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_count", 32'(obs_q.size()), 32'h1);
    check("bp_accept_frame", 32'(obs_q.size() > 0 ? obs_q[0] : 16'h0), 32'({a[7:0], b[7:0]}));
    @(negedge clk);
    check("bp_valid_clears", 32'(rx_valid), 32'h0);

    // Reset in the middle of a right word
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_word(1'b0, $urandom | 32'h81, 8);
      add_word(1'b1, $urandom | 32'h81, 8);
    end
    build();
    model();
    obs_q.delete();
    send(sd_q.size() - 4);
    repeat (30) @(posedge clk);
    compare_frames("pre_reset");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_left",    32'(rx_left),  32'h0);
    check("midrst_right",   32'(rx_right), 32'h0);
    check("midrst_valid",   32'(rx_valid), 32'h0);
    check("midrst_overrun", 32'(overrun),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    words.delete();
    add_word(1'b1, $urandom, 4);
    add_word(1'b0, $urandom, 8);
    add_word(1'b1, $urandom, 8);
    add_word(1'b0, $urandom, 8);
    run_stream();
    compare_frames("post_reset");

    // Right word with no preceding left produces nothing
    do_reset();
    add_word(1'b0, $urandom, 8);
    add_word(1'b1, $urandom, 8);
    add_word(1'b0, $urandom, 8);
    run_stream();
    compare_frames("lone_right");
    check("lone_right_valid", 32'(rx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
